// File: rtl/rgb_pwm_fader_if.sv
// Colour request in, PWM LED drive and settled flag out.
// Level-sampled bundle with no handshake.
interface rgb_pwm_fader_if;
   logic [2:0] rgb;
   logic [2:0] led;
   logic       settled;

   modport master (
      output rgb,
      input  led,
      input  settled
   );

   modport slave (
      input  rgb,
      output led,
      output settled
   );
endinterface

// File: rtl/rgb_pwm_fader.sv
// RGB on/off bits to linearly faded PWM LED drive.
// Optional gamma squaring of duty: define RGB_PWM_GAMMA_EN.
module rgb_pwm_fader #(
   parameter int PWM_BITS   = 8,
   parameter int MAX_DUTY   = 256,
   parameter int FADE_TICKS = 1024
) (
   input logic            clk,
   input logic            rst,
   rgb_pwm_fader_if.slave bus
);
   localparam int DW = PWM_BITS + 1;
   localparam int FW = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
   localparam logic [DW-1:0] FULL = DW'(MAX_DUTY);
   localparam logic [FW-1:0] LAST = FW'(FADE_TICKS - 1);

   logic [2:0]                rgb_q;
   logic [PWM_BITS-1:0]       pwm_cnt;
   logic [FW-1:0]             fade_cnt;
   logic [2:0][DW-1:0]        duty;
   logic [2:0][DW-1:0]        target;
   logic [2:0][DW-1:0]        duty_eff;
   logic [2:0]                match;
   logic [2:0]                led_q;
   logic                      step;

   assign step = (fade_cnt == LAST);

   always_comb begin
      target = '0;
      match  = '0;
      for (int i = 0; i < 3; i++) begin
         target[i] = rgb_q[i] ? FULL : '0;
         match[i]  = (duty[i] == target[i]);
      end
   end

`ifdef RGB_PWM_GAMMA_EN
   logic [2:0][2*DW-1:0] sq;

   // Squaring keeps both endpoints: 0 -> 0, 2^B -> 2^B.
   always_comb begin
      sq       = '0;
      duty_eff = '0;
      for (int i = 0; i < 3; i++) begin
         sq[i] = {{DW{1'b0}}, duty[i]} *
                 {{DW{1'b0}}, duty[i]};
         duty_eff[i] = DW'(sq[i] >> PWM_BITS);
      end
   end
`else
   always_comb begin
      duty_eff = duty;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q    <= '0;
         pwm_cnt  <= '0;
         fade_cnt <= '0;
      end else begin
         rgb_q    <= bus.rgb;
         pwm_cnt  <= pwm_cnt + 1'b1;
         fade_cnt <= step ? '0 : fade_cnt + 1'b1;
      end
   end

   // Moving one count per step toward target cannot overshoot.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty <= '0;
      end else if (step) begin
         for (int i = 0; i < 3; i++) begin
            if (duty[i] < target[i]) begin
               duty[i] <= duty[i] + 1'b1;
            end else if (duty[i] > target[i]) begin
               duty[i] <= duty[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            led_q[i] <= ({1'b0, pwm_cnt} < duty_eff[i]);
         end
      end
   end

   assign bus.led     = led_q;
   assign bus.settled = &match;
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: two instances checked in lockstep
// against a time-indexed model, plus vector table and corner cases.
module tb_rgb_pwm_fader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   bit   armed = 1'b0;

   always #5 clk = ~clk;

   rgb_pwm_fader_if ifa ();
   rgb_pwm_fader_if ifb ();

   rgb_pwm_fader #(.PWM_BITS(4), .MAX_DUTY(16), .FADE_TICKS(2)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   rgb_pwm_fader #(.PWM_BITS(4), .MAX_DUTY(10), .FADE_TICKS(1)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   // Reference model: state derived from cycles elapsed since reset.
   int         maxd [2] = '{16, 10};
   int         fticks [2] = '{2, 1};
   int         m_t [2];
   logic [2:0] m_q [2];
   int         m_duty [2][3];
   logic [2:0] m_led [2];

   function automatic int eff(int d);
`ifdef RGB_PWM_GAMMA_EN
      return (d * d) / 16;
`else
      return d;
`endif
   endfunction

   function automatic bit m_settled(int k);
      bit s = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (m_duty[k][i] != (m_q[k][i] ? maxd[k] : 0)) s = 1'b0;
      end
      return s;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_t[k]   <= 0;
            m_q[k]   <= 3'b000;
            m_led[k] <= 3'b000;
            for (int i = 0; i < 3; i++) m_duty[k][i] <= 0;
         end else begin
            for (int i = 0; i < 3; i++) begin
               int tgt;
               m_led[k][i] <= ((m_t[k] % 16) < eff(m_duty[k][i]));
               tgt = m_q[k][i] ? maxd[k] : 0;
               if (m_t[k] % fticks[k] == fticks[k] - 1) begin
                  if (m_duty[k][i] < tgt) m_duty[k][i] <= m_duty[k][i] + 1;
                  else if (m_duty[k][i] > tgt) m_duty[k][i] <= m_duty[k][i] - 1;
               end
            end
            m_q[k] <= (k == 0) ? ifa.rgb : ifb.rgb;
            m_t[k] <= m_t[k] + 1;
         end
      end
      armed <= 1'b1;
   end

   always @(negedge clk) begin
      if (armed) begin
         tests = tests + 4;
         if (ifa.led !== m_led[0]) begin
            fails++;
            $display("FAIL lockA_led t=%0t got %b want %b", $time, ifa.led, m_led[0]);
         end
         if (ifa.settled !== m_settled(0)) begin
            fails++;
            $display("FAIL lockA_settled t=%0t got %b want %b", $time, ifa.settled, m_settled(0));
         end
         if (ifb.led !== m_led[1]) begin
            fails++;
            $display("FAIL lockB_led t=%0t got %b want %b", $time, ifb.led, m_led[1]);
         end
         if (ifb.settled !== m_settled(1)) begin
            fails++;
            $display("FAIL lockB_settled t=%0t got %b want %b", $time, ifb.settled, m_settled(1));
         end
      end
   end

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(string name, int act, int lo, int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s got %0d want %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      logic [2:0] rgb;
      int         hold;
      logic       exp_settled;
      logic [2:0] exp_led;
      bit         led_valid;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int n;
      int hi;
      vecs[0] = '{3'b101, 40, 1'b1, 3'b101, 1'b1};
      vecs[1] = '{3'b010, 3,  1'b0, 3'b000, 1'b0};
      vecs[2] = '{3'b010, 40, 1'b1, 3'b010, 1'b1};
      vecs[3] = '{3'b111, 40, 1'b1, 3'b111, 1'b1};
      vecs[4] = '{3'b000, 3,  1'b0, 3'b000, 1'b0};
      vecs[5] = '{3'b000, 40, 1'b1, 3'b000, 1'b1};
      vecs[6] = '{3'b110, 40, 1'b1, 3'b110, 1'b1};
      vecs[7] = '{3'b001, 40, 1'b1, 3'b001, 1'b1};

      // Reset held with a request pending
      ifa.rgb = 3'b100;
      ifb.rgb = 3'b000;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_led", int'(ifa.led), 0);
         chk("rst_settled", int'(ifa.settled), 1);
      end
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 60 && n == 0; i++) begin
         @(negedge clk);
         if (i == 1) chk("rel_settled_drop", int'(ifa.settled), 0);
         if (ifa.settled) n = i + 1;
      end
      chk_rng("ramp_cycles", n, 30, 34);
      cyc(2);
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         hi += int'(ifa.led[2]);
      end
      chk("full_on_r", hi, 16);

      // Vector table on instance A
      for (int v = 0; v < 8; v++) begin
         ifa.rgb = vecs[v].rgb;
         cyc(vecs[v].hold);
         chk($sformatf("vec%0d_settled", v), int'(ifa.settled), int'(vecs[v].exp_settled));
         if (vecs[v].led_valid) begin
            chk($sformatf("vec%0d_led", v), int'(ifa.led), int'(vecs[v].exp_led));
         end
      end

      // Reversal mid-ramp at duty 5
      ifa.rgb = 3'b000;
      cyc(40);
      ifa.rgb = 3'b001;
      n = 0;
      for (int i = 0; i < 40 && m_duty[0][0] != 5; i++) begin
         @(negedge clk);
         n++;
      end
      chk("rev_reach5", m_duty[0][0], 5);
      ifa.rgb = 3'b000;
      n = 0;
      for (int i = 0; i < 40 && n == 0; i++) begin
         @(negedge clk);
         if (ifa.settled) n = i + 1;
      end
      chk_rng("rev_cycles", n, 8, 12);

      // All-on, reset at duty 6
      ifa.rgb = 3'b111;
      for (int i = 0; i < 40 && m_duty[0][0] != 6; i++) @(negedge clk);
      chk("allon_reach6", m_duty[0][0], 6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_led", int'(ifa.led), 0);
      chk("midrst_settled", int'(ifa.settled), 1);
      cyc(40);
      chk("allon_resettle", int'(ifa.settled), 1);
      chk("allon_led", int'(ifa.led), 7);

      // Instance B: single-cycle steps, MAX_DUTY 10
      ifb.rgb = 3'b100;
      n = 0;
      for (int i = 0; i < 40 && n == 0; i++) begin
         @(negedge clk);
         if (ifb.settled) n = i + 1;
      end
      chk("b_ramp_cycles", n, 11);
      cyc(3);
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         hi += int'(ifb.led[2]);
      end
`ifdef RGB_PWM_GAMMA_EN
      chk("b_duty10_hi", hi, 6);
`else
      chk("b_duty10_hi", hi, 10);
`endif

      // Random hold/change sequences under lockstep checking
      for (int r = 0; r < 150; r++) begin
         ifa.rgb = 3'($urandom);
         ifb.rgb = 3'($urandom);
         cyc(int'($urandom_range(1, 40)));
         if ($urandom_range(0, 30) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Output-side driver for the 3-bit RGB colour bus produced by the light sequencing logic.
- Converts each on/off colour bit into a PWM LED drive.
- On a colour change, each channel ramps linearly between 0 and full brightness instead of switching instantly.
- Sits between the colour FSM and the board LED pins; no handshake, the colour bus is level-sampled.

Parameters:
- PWM_BITS, 8: width of the free-running PWM counter; PWM period = 2^PWM_BITS clk cycles.
- MAX_DUTY, 256: full-brightness duty value, legal range 1..2^PWM_BITS. Duty registers are PWM_BITS+1 bits wide.
- FADE_TICKS, 1024: clk cycles per fade step, legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous and active-high; one clock.
- rgb  input  3  colour request, bit2=R, bit1=G, bit0=B; any combination legal, including 3'b111.
- led  output 3  PWM LED drive, same bit order, active-high.
- settled  output 1  high when every channel's duty equals its target.

Behaviour:
- Input register: rgb_q <= rgb every cycle. All internal decisions use rgb_q, which adds 1 cycle of input latency. Reset value 3'b000.
- Per-channel target: target[i] = rgb_q[i] ? MAX_DUTY : 0.
- PWM counter:
  - pwm_cnt, PWM_BITS wide, +1 every cycle, wraps from 2^PWM_BITS-1 to 0.
  - Reset value 0.
- Fade timer:
  - fade_cnt counts 0..FADE_TICKS-1, then wraps to 0.
  - step pulse = (fade_cnt == FADE_TICKS-1).
  - FADE_TICKS=1 gives step every cycle.
  - Reset value 0.
- Duty update, per channel i, only on a step cycle:
  - duty[i] < target[i] -> duty[i] + 1
  - duty[i] > target[i] -> duty[i] - 1
  - equal -> hold
  - No overshoot or wrap. duty stays within 0..MAX_DUTY.
  - Reset value 0.
- Reversal mid-fade: if rgb changes during a ramp, the ramp reverses from the current duty on the next step. duty never jumps.
- Output:
  - led[i] <= (pwm_cnt < duty_eff[i]), registered, 1 cycle after the pwm_cnt value it is compared against.
  - duty_eff = duty when gamma is disabled.
  - duty=0 -> constantly 0.
  - duty=2^PWM_BITS -> constantly 1.
  - Reset value 3'b000.
- settled: combinational from registers only, = AND over i of (duty[i]==target[i]). After reset it is 1, because duty=0 and rgb_q=0.
- Ramp time: a full 0->MAX_DUTY ramp takes MAX_DUTY*FADE_TICKS cycles, +/- one step of phase.
- Reset mid-fade: all counters, duty, rgb_q and led return to 0 on the next edge. No residual ramp.
- Simultaneous events: a step and an rgb change in the same cycle are safe. The step uses the old rgb_q, and the new value applies from the following step.
- No internal state exists beyond these listed registers.

Optional Feature:
- Macro RGB_PWM_GAMMA_EN.
- Defined: duty_eff[i] = (duty[i]*duty[i]) >> PWM_BITS.
  - Computed combinationally, with a product width of 2*(PWM_BITS+1).
  - This gives a perceptually linear fade.
  - Endpoints are preserved: 0->0, and 2^PWM_BITS -> 2^PWM_BITS.
- Undefined: duty_eff = duty, no multiplier is synthesised, and behaviour is as above.

Test Plan (PWM_BITS=4, MAX_DUTY=16, FADE_TICKS=2 unless noted):
- Reset check: hold rst 3 cycles with rgb=3'b100, then release -> during rst, led=000 and settled=1. After release, settled drops by cycle 2, R duty reaches 16 after 32 +/- 2 cycles, then led[2] is constant 1 and settled=1.
- Steady duty: force rgb=3'b010 and wait until settled, then set rgb=3'b000 -> G duty decrements 1 per 2 cycles. When duty=8, led[1] is high exactly 8 of every 16 cycles, on pwm_cnt 0..7 delayed by 1 cycle.
- Reversal: rgb 3'b001 until B duty=5, then rgb=3'b000 -> duty goes 5,4,3,... with no value skipped or exceeding 5. It reaches 0 after 10 +/- 2 cycles.
- All-on plus reset mid-fade: rgb=3'b111, then pulse rst when duties=6 -> the next cycle all duty=0 and led=000. Ramp restarts from 0 and all three channels stay equal every cycle.
- FADE_TICKS=1, MAX_DUTY=10: rgb 000->100 -> R duty reaches 10 in 11 cycles including the input register. It then never exceeds 10, and led[2] is high 10 of 16 PWM cycles.
- With RGB_PWM_GAMMA_EN, R held at duty=8 -> led[2] is high 4 of every 16 cycles. At duty 16 it is constant 1. Without the macro, duty=8 gives 8 of 16.
